stack_engine: RTL and testbench
===============================

Name: stack_engine

Overview:
- Sequencer that executes x86 PUSH r32 / POP r32 micro-operations.
- Drives the register file's two read ports and its write port: it reads ESP and the source register, and writes back ESP and the destination register.
- Issues one 32-bit stack memory access per operation over a req/ack port.
- Sits between the decoder's issue stage and the register file / data-memory port. Flat stack addressing: the SS base is not applied.

Parameters:
- STACK_STEP, 4, byte decrement/increment applied to ESP per operation.
- MEM_TIMEOUT, 255, max cycles to wait for i_mem_ack before aborting (8-bit counter, range 1..255).

Ports:
- i_clk  in  1  clock, rising-edge logic.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  operation request.
- o_ready  out  1  engine can accept a request (IDLE).
- i_pop  in  1  0 = PUSH, 1 = POP; sampled on accept.
- i_reg  in  5  source (PUSH) or destination (POP) register code; sampled on accept.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  one-cycle pulse coincident with o_done on abort.
- o_rf_ctrl_read1  out  5  read port 1 select (always ESP = 5'd7).
- i_rf_read_val1  in  32  read port 1 data.
- o_rf_ctrl_read2  out  5  read port 2 select.
- i_rf_read_val2  in  32  read port 2 data.
- o_rf_write  out  1  write enable; the register file commits on the falling edge of the same cycle.
- o_rf_ctrl_write  out  5  write select.
- o_rf_write_val  out  32  write data.
- o_mem_req  out  1  memory request, held until ack.
- o_mem_we  out  1  1 = write (PUSH), 0 = read (POP).
- o_mem_addr  out  32  byte address.
- o_mem_wdata  out  32  write data.
- i_mem_ack  in  1  access complete; may assert in the first req cycle.
- i_mem_rdata  in  32  read data, valid with ack.

Behaviour:
- **Reset (async, i_rst_n=0):**
  - state=IDLE; o_ready=1.
  - o_done, o_err, o_rf_write, o_mem_req, o_mem_we = 0.
  - o_rf_ctrl_read1=7; o_rf_ctrl_read2=0; o_rf_ctrl_write=0.
  - o_rf_write_val, o_mem_addr, o_mem_wdata = 0; timeout counter=0.
  - Reset mid-operation abandons it: pending mem req drops immediately, no further RF writes. An ESP write already committed in WB_ESP is not undone.
- **Register file timing:** read selects are registered. The RF read is combinational, so data is sampled at the next rising edge.
- **IDLE:**
  - o_ready=1. Accept when i_valid & o_ready: latch i_pop and i_reg, drive o_rf_ctrl_read2=i_reg, go to READ.
  - i_valid while not in IDLE is ignored (o_ready=0).
- **READ:**
  - Latch esp=i_rf_read_val1 and src=i_rf_read_val2.
  - If i_reg > 7 (segment/control/IP codes): go to DONE with err.
  - Otherwise compute new_esp:
    - PUSH: esp - STACK_STEP.
    - POP: esp + STACK_STEP.
    - Both mod 2^32: PUSH at ESP=0 gives 0xFFFFFFFC; POP at 0xFFFFFFFC gives 0.
  - Go to MEM.
- **MEM:**
  - o_mem_req=1. o_mem_addr is new_esp for PUSH, esp for POP. o_mem_we=!pop. o_mem_wdata=src (PUSH); otherwise 0.
  - Address/data stay stable while req is high.
  - Counter increments each cycle without ack.
  - On i_mem_ack: drop req next cycle, latch i_mem_rdata (POP), go to WB_ESP.
  - If the counter reaches MEM_TIMEOUT without ack: drop req, go to DONE with err; no RF writes.
- **WB_ESP:** o_rf_write=1, o_rf_ctrl_write=7, o_rf_write_val=new_esp. Next state: PUSH → DONE, POP → WB_DST.
- **WB_DST (POP only):**
  - o_rf_write=1, o_rf_ctrl_write=i_reg, o_rf_write_val=popped data. Next state: DONE.
  - POP ESP therefore leaves ESP = popped value, per x86.
- **DONE:** o_done=1 (plus o_err=1 if aborted) for one cycle, then IDLE.
- **PUSH ESP** stores the pre-decrement ESP (src read in READ).
- **Latency:**
  - PUSH with zero-wait ack: 4 cycles from accept to o_done.
  - POP with zero-wait ack: 5 cycles.
  - Each ack wait cycle adds 1.
- Back-to-back: a new accept is possible in the cycle after o_done.
- o_rf_write is never high outside WB_ESP/WB_DST.

Test Plan:
- Preload ESP=0x1000, EAX(0)=0xDEADBEEF; PUSH EAX, ack immediate -> mem write addr 0x0FFC data 0xDEADBEEF; ESP=0x0FFC; o_done at accept+4, o_err=0.
- ESP=0x0FFC, memory returns 0x12345678 after 3 wait cycles; POP EBX(1) -> mem read addr 0x0FFC; ESP=0x1000; EBX=0x12345678; o_done at accept+8.
- ESP=0x2000; POP ESP, rdata=0x5550 -> ESP=0x5550 at end. PUSH ESP with ESP=0x2000 -> stored data 0x2000, ESP=0x1FFC.
- Wrap: ESP=0; PUSH ECX -> addr 0xFFFFFFFC, ESP=0xFFFFFFFC. Then POP -> ESP=0.
- Errors:
  - i_reg=8 (CS): no mem req, no RF write; o_done=o_err=1 at accept+2.
  - Ack withheld with MEM_TIMEOUT=4: req drops after 4 cycles, o_err pulse, ESP unchanged.
- Assert i_rst_n=0 asynchronously during MEM of a PUSH -> o_mem_req falls without a clock edge; ESP unchanged; o_ready=1 after release. Also check that i_valid asserted during a busy op is ignored.

Source files
------------

// File: rtl/stack_engine_if.sv
// +----------------------------------------------------------------------+
// | stack_engine_if : 32-bit stack memory req/ack bus   | rev 1.0        |
// +----------------------------------------------------------------------+
`default_nettype none

interface stack_engine_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/stack_engine.sv
// +----------------------------------------------------------------------+
// | stack_engine : x86 PUSH/POP r32 sequencer (RF + stack mem) | rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module stack_engine #(
  parameter int unsigned STACK_STEP  = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst_n,
  input  wire logic        i_valid,
  output logic             o_ready,
  input  wire logic        i_pop,
  input  wire logic [4:0]  i_reg,
  output logic             o_done,
  output logic             o_err,
  output logic [4:0]       o_rf_ctrl_read1,
  input  wire logic [31:0] i_rf_read_val1,
  output logic [4:0]       o_rf_ctrl_read2,
  input  wire logic [31:0] i_rf_read_val2,
  output logic             o_rf_write,
  output logic [4:0]       o_rf_ctrl_write,
  output logic [31:0]      o_rf_write_val,
  stack_engine_if.master   mem
);

  localparam logic [4:0]  c_reg_esp  = 5'd7;
  localparam logic [4:0]  c_reg_max  = 5'd7;
  localparam logic [31:0] c_step     = 32'(STACK_STEP);
  localparam logic [7:0]  c_timeout  = 8'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_MEM    = 3'd2,
    S_WB_ESP = 3'd3,
    S_WB_DST = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        pop_q, pop_d;
  logic [4:0]  reg_q, reg_d;
  logic [31:0] new_esp_q, new_esp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [4:0]  rd2_sel_q, rd2_sel_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  wr_sel_q, wr_sel_d;
  logic [31:0] wr_val_q, wr_val_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] esp_dec, esp_inc;

  assign esp_dec = i_rf_read_val1 - c_step;
  assign esp_inc = i_rf_read_val1 + c_step;

  always_comb begin
    state_d   = state_q;
    pop_d     = pop_q;
    reg_d     = reg_q;
    new_esp_d = new_esp_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd2_sel_d = rd2_sel_q;
    rf_we_d   = 1'b0;
    wr_sel_d  = wr_sel_q;
    wr_val_d  = wr_val_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (i_valid && ready_q) begin
          pop_d     = i_pop;
          reg_d     = i_reg;
          rd2_sel_d = i_reg;
          ready_d   = 1'b0;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        // Codes above 7 are segment/control/IP registers: no stack access.
        if (reg_q > c_reg_max) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          new_esp_d = pop_q ? esp_inc : esp_dec;
          addr_d    = pop_q ? i_rf_read_val1 : esp_dec;
          we_d      = !pop_q;
          wdata_d   = pop_q ? 32'd0 : i_rf_read_val2;
          req_d     = 1'b1;
          cnt_d     = 8'd0;
          state_d   = S_MEM;
        end
      end
      S_MEM: begin
        if (mem.mem_ack) begin
          req_d    = 1'b0;
          rdata_d  = pop_q ? mem.mem_rdata : rdata_q;
          rf_we_d  = 1'b1;
          wr_sel_d = c_reg_esp;
          wr_val_d = new_esp_q;
          state_d  = S_WB_ESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == c_timeout) begin
            req_d   = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_WB_ESP: begin
        if (pop_q) begin
          rf_we_d  = 1'b1;
          wr_sel_d = reg_q;
          wr_val_d = rdata_q;
          state_d  = S_WB_DST;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WB_DST: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      pop_q     <= 1'b0;
      reg_q     <= 5'd0;
      new_esp_q <= 32'd0;
      rdata_q   <= 32'd0;
      cnt_q     <= 8'd0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd2_sel_q <= 5'd0;
      rf_we_q   <= 1'b0;
      wr_sel_q  <= 5'd0;
      wr_val_q  <= 32'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pop_q     <= pop_d;
      reg_q     <= reg_d;
      new_esp_q <= new_esp_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd2_sel_q <= rd2_sel_d;
      rf_we_q   <= rf_we_d;
      wr_sel_q  <= wr_sel_d;
      wr_val_q  <= wr_val_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign o_ready         = ready_q;
  assign o_done          = done_q;
  assign o_err           = err_q;
  assign o_rf_ctrl_read1 = c_reg_esp;
  assign o_rf_ctrl_read2 = rd2_sel_q;
  assign o_rf_write      = rf_we_q;
  assign o_rf_ctrl_write = wr_sel_q;
  assign o_rf_write_val  = wr_val_q;
  assign mem.mem_req     = req_q;
  assign mem.mem_we      = we_q;
  assign mem.mem_addr    = addr_q;
  assign mem.mem_wdata   = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_engine.sv
// +----------------------------------------------------------------------+
// | tb_stack_engine : directed bench with RF and memory models | rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_stack_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_pop = 1'b0;
  logic [4:0]  i_reg = 5'd0;
  logic        o_ready, o_done, o_err, o_rf_write;
  logic [4:0]  rd1_sel, rd2_sel, wr_sel;
  logic [31:0] rd1_val, rd2_val, wr_val;

  int checks = 0;
  int failures = 0;

  logic [31:0] rf [0:7];
  int          rf_wr_cnt = 0;

  int          mem_wait = 0;
  logic        withhold = 1'b0;
  logic [31:0] rdata_val = 32'd0;
  int          req_wait = 0;
  int          req_seen = 0;
  int          acc_cnt = 0;
  logic [31:0] acc_addr = 32'd0;
  logic [31:0] acc_wdata = 32'd0;
  logic        acc_we = 1'b0;

  stack_engine_if mem_bus();

  stack_engine #(.STACK_STEP(4), .MEM_TIMEOUT(4)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_pop           (i_pop),
    .i_reg           (i_reg),
    .o_done          (o_done),
    .o_err           (o_err),
    .o_rf_ctrl_read1 (rd1_sel),
    .i_rf_read_val1  (rd1_val),
    .o_rf_ctrl_read2 (rd2_sel),
    .i_rf_read_val2  (rd2_val),
    .o_rf_write      (o_rf_write),
    .o_rf_ctrl_write (wr_sel),
    .o_rf_write_val  (wr_val),
    .mem             (mem_bus.master)
  );

  always #5 clk = ~clk;

  assign rd1_val = (rd1_sel < 5'd8) ? rf[rd1_sel[2:0]] : 32'd0;
  assign rd2_val = (rd2_sel < 5'd8) ? rf[rd2_sel[2:0]] : 32'd0;

  // Register file commits on the falling edge of the write cycle.
  always @(negedge clk) begin
    if (o_rf_write) begin
      rf_wr_cnt = rf_wr_cnt + 1;
      if (wr_sel < 5'd8) rf[wr_sel[2:0]] = wr_val;
    end
  end

  // Memory responder: acks after mem_wait cycles of req, or never when withheld.
  always @(negedge clk) begin
    if (mem_bus.mem_req) begin
      req_seen = req_seen + 1;
      if (!withhold && req_wait == mem_wait) begin
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = rdata_val;
        acc_addr  = mem_bus.mem_addr;
        acc_we    = mem_bus.mem_we;
        acc_wdata = mem_bus.mem_wdata;
        acc_cnt   = acc_cnt + 1;
      end else begin
        mem_bus.mem_ack = 1'b0;
      end
      req_wait = req_wait + 1;
    end else begin
      mem_bus.mem_ack = 1'b0;
      req_wait = 0;
    end
  end

  task automatic run_op(input logic pop, input logic [4:0] r, output int lat, output logic err);
    @(negedge clk);
    for (int k = 0; k < 20 && !o_ready; k++) @(negedge clk);
    i_valid = 1'b1;
    i_pop   = pop;
    i_reg   = r;
    lat = -1;
    err = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      if (o_done) begin
        lat = c;
        err = o_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 8; i++) rf[i] = 32'd0;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_ready, o_done, o_err, o_rf_write} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl: ready/done/err/rfwe=%b required 1000", {o_ready, o_done, o_err, o_rf_write});
    end
    checks++;
    if ({mem_bus.mem_req, mem_bus.mem_we} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mem_ctrl: req/we=%b required 00", {mem_bus.mem_req, mem_bus.mem_we});
    end
    checks++;
    if ({rd1_sel, rd2_sel, wr_sel} !== {5'd7, 5'd0, 5'd0}) begin
      failures++;
      $display("FAIL reset_sel: rd1/rd2/wr=%0d/%0d/%0d required 7/0/0", rd1_sel, rd2_sel, wr_sel);
    end
    checks++;
    if ({wr_val, mem_bus.mem_addr, mem_bus.mem_wdata} !== 96'd0) begin
      failures++;
      $display("FAIL reset_data: wval=%h addr=%h wdata=%h required all 0", wr_val, mem_bus.mem_addr, mem_bus.mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_push;
    int lat;
    logic err;
    rf[7] = 32'h0000_1000;
    rf[0] = 32'hDEAD_BEEF;
    mem_wait = 0;
    run_op(1'b0, 5'd0, lat, err);
    checks++;
    if (lat !== 4 || err !== 1'b0) begin
      failures++;
      $display("FAIL push_latency: lat=%0d err=%b required 4/0", lat, err);
    end
    checks++;
    if (acc_addr !== 32'h0000_0FFC || acc_we !== 1'b1 || acc_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL push_mem: addr=%h we=%b data=%h required 00000ffc/1/deadbeef", acc_addr, acc_we, acc_wdata);
    end
    checks++;
    if (rf[7] !== 32'h0000_0FFC) begin
      failures++;
      $display("FAIL push_esp: esp=%h required 00000ffc", rf[7]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_done !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL push_done_pulse: done=%b ready=%b required 0/1", o_done, o_ready);
    end
  endtask

  task automatic test_pop_wait;
    int lat;
    logic err;
    rdata_val = 32'h1234_5678;
    mem_wait = 3;
    run_op(1'b1, 5'd1, lat, err);
    mem_wait = 0;
    checks++;
    if (lat !== 8 || err !== 1'b0) begin
      failures++;
      $display("FAIL pop_wait_latency: lat=%0d err=%b required 8/0", lat, err);
    end
    checks++;
    if (acc_addr !== 32'h0000_0FFC || acc_we !== 1'b0) begin
      failures++;
      $display("FAIL pop_wait_mem: addr=%h we=%b required 00000ffc/0", acc_addr, acc_we);
    end
    checks++;
    if (rf[7] !== 32'h0000_1000 || rf[1] !== 32'h1234_5678) begin
      failures++;
      $display("FAIL pop_wait_rf: esp=%h ebx=%h required 00001000/12345678", rf[7], rf[1]);
    end
  endtask

  task automatic test_esp_ops;
    int lat;
    logic err;
    @(negedge clk);
    rf[7] = 32'h0000_2000;
    rdata_val = 32'h0000_5550;
    run_op(1'b1, 5'd7, lat, err);
    checks++;
    if (lat !== 5 || rf[7] !== 32'h0000_5550) begin
      failures++;
      $display("FAIL pop_esp: lat=%0d esp=%h required 5/00005550", lat, rf[7]);
    end
    @(negedge clk);
    rf[7] = 32'h0000_2000;
    run_op(1'b0, 5'd7, lat, err);
    checks++;
    if (acc_wdata !== 32'h0000_2000 || acc_addr !== 32'h0000_1FFC || rf[7] !== 32'h0000_1FFC) begin
      failures++;
      $display("FAIL push_esp: data=%h addr=%h esp=%h required 00002000/00001ffc/00001ffc", acc_wdata, acc_addr, rf[7]);
    end
  endtask

  task automatic test_wrap;
    int lat;
    logic err;
    @(negedge clk);
    rf[7] = 32'h0000_0000;
    rf[2] = 32'hCAFE_0002;
    run_op(1'b0, 5'd2, lat, err);
    checks++;
    if (acc_addr !== 32'hFFFF_FFFC || acc_wdata !== 32'hCAFE_0002 || rf[7] !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_push: addr=%h data=%h esp=%h required fffffffc/cafe0002/fffffffc", acc_addr, acc_wdata, rf[7]);
    end
    rdata_val = 32'hA5A5_0003;
    run_op(1'b1, 5'd3, lat, err);
    checks++;
    if (acc_addr !== 32'hFFFF_FFFC || rf[7] !== 32'h0000_0000 || rf[3] !== 32'hA5A5_0003) begin
      failures++;
      $display("FAIL wrap_pop: addr=%h esp=%h edx=%h required fffffffc/00000000/a5a50003", acc_addr, rf[7], rf[3]);
    end
  endtask

  task automatic test_bad_reg;
    int lat;
    logic err;
    int req0, wr0;
    req0 = req_seen;
    wr0  = rf_wr_cnt;
    run_op(1'b0, 5'd8, lat, err);
    checks++;
    if (lat !== 2 || err !== 1'b1) begin
      failures++;
      $display("FAIL bad_reg_done: lat=%0d err=%b required 2/1", lat, err);
    end
    checks++;
    if (req_seen !== req0 || rf_wr_cnt !== wr0) begin
      failures++;
      $display("FAIL bad_reg_side_effect: reqs=%0d rfwr=%0d required 0/0", req_seen - req0, rf_wr_cnt - wr0);
    end
  endtask

  task automatic test_timeout;
    int lat;
    logic err;
    int req0, wr0;
    @(negedge clk);
    rf[7] = 32'h0000_3000;
    withhold = 1'b1;
    req0 = req_seen;
    wr0  = rf_wr_cnt;
    run_op(1'b0, 5'd0, lat, err);
    withhold = 1'b0;
    checks++;
    if (lat !== 6 || err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_done: lat=%0d err=%b required 6/1", lat, err);
    end
    checks++;
    if (req_seen - req0 !== 4 || rf_wr_cnt !== wr0 || rf[7] !== 32'h0000_3000) begin
      failures++;
      $display("FAIL timeout_effect: req_cycles=%0d rfwr=%0d esp=%h required 4/0/00003000",
               req_seen - req0, rf_wr_cnt - wr0, rf[7]);
    end
  endtask

  task automatic test_busy_ignore;
    int acc0;
    logic busy_ok;
    logic seen_done;
    @(negedge clk);
    rf[7] = 32'h0000_4000;
    acc0 = acc_cnt;
    for (int k = 0; k < 20 && !o_ready; k++) @(negedge clk);
    i_valid = 1'b1;
    i_pop   = 1'b0;
    i_reg   = 5'd0;
    @(posedge clk);
    #1;
    i_pop = 1'b1;
    i_reg = 5'd5;
    busy_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (o_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    seen_done = o_done;
    for (int k = 0; k < 20 && !seen_done; k++) begin
      @(posedge clk);
      #1;
      seen_done = o_done;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!busy_ok || !seen_done || acc_cnt - acc0 !== 1 || rf[7] !== 32'h0000_3FFC || rd2_sel !== 5'd0) begin
      failures++;
      $display("FAIL busy_ignore: busy_ok=%b done=%b accesses=%0d esp=%h rd2=%0d required 1/1/1/00003ffc/0",
               busy_ok, seen_done, acc_cnt - acc0, rf[7], rd2_sel);
    end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    logic err;
    @(negedge clk);
    rf[7] = 32'h0000_6000;
    run_op(1'b0, 5'd0, lat1, err);
    run_op(1'b0, 5'd0, lat2, err);
    checks++;
    if (lat1 !== 4 || lat2 !== 4 || rf[7] !== 32'h0000_5FF8) begin
      failures++;
      $display("FAIL back_to_back: lat=%0d/%0d esp=%h required 4/4/00005ff8", lat1, lat2, rf[7]);
    end
  endtask

  task automatic test_async_reset;
    int wr0;
    logic got_req;
    @(negedge clk);
    rf[7] = 32'h0000_5000;
    withhold = 1'b1;
    wr0 = rf_wr_cnt;
    for (int k = 0; k < 20 && !o_ready; k++) @(negedge clk);
    i_valid = 1'b1;
    i_pop   = 1'b0;
    i_reg   = 5'd0;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    got_req = 1'b0;
    for (int k = 0; k < 10 && !got_req; k++) begin
      @(posedge clk);
      #1;
      got_req = mem_bus.mem_req;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!got_req || mem_bus.mem_req !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_drop: got_req=%b req=%b ready=%b required 1/0/1", got_req, mem_bus.mem_req, o_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    withhold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_ready !== 1'b1 || rf[7] !== 32'h0000_5000 || rf_wr_cnt !== wr0) begin
      failures++;
      $display("FAIL async_reset_after: ready=%b esp=%h rfwr=%0d required 1/00005000/0", o_ready, rf[7], rf_wr_cnt - wr0);
    end
  endtask

  initial begin
    test_reset;
    test_push;
    test_pop_wait;
    test_esp_ops;
    test_wrap;
    test_bad_reg;
    test_timeout;
    test_busy_ignore;
    test_back_to_back;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
